// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full adder iterated WIDTH times, LSB first,
// with registered carry and ARM-style {N,Z,C,V} flags reported with a one-cycle done pulse.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_op_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [3:0]       r_flags;

  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_res_next;
  logic             w_ready;

  // The single shared full adder.
  assign w_sum      = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_cout     = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));
  assign w_res_next = {w_sum, r_result[WIDTH-1:1]};
  assign w_ready    = (r_state == StIdle) || (r_state == StDone);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_flags  <= 4'b0000;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle, StDone: begin
          if (i_start && w_ready) begin
            // Subtraction as A + ~B + 1: invert B on capture, preset carry-in.
            r_a_sh   <= i_a;
            r_b_sh   <= i_op_sub ? ~i_b : i_b;
            r_carry  <= i_op_sub;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= 4'b0000;
            r_busy   <= 1'b1;
            r_state  <= StRun;
          end else begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        StRun: begin
          r_result <= w_res_next;
          r_carry  <= w_cout;
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            // r_carry is the carry into the MSB here; V compares it with the carry out.
            r_flags <= {w_res_next[WIDTH-1], (w_res_next == '0), w_cout, r_carry ^ w_cout};
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_flags  = r_flags;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed and random add/sub at WIDTH=8 and 64
// against an arithmetic reference model.
module tb_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        st8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [7:0]  res8;
  logic [3:0]  fl8;

  logic        st64 = 1'b0, sub64 = 1'b0;
  logic [63:0] a64 = '0, b64 = '0;
  logic        busy64, done64;
  logic [63:0] res64;
  logic [3:0]  fl64;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(st8), .i_op_sub(sub8), .i_a(a8), .i_b(b8),
    .o_busy(busy8), .o_done(done8), .o_result(res8), .o_flags(fl8)
  );

  serial_adder_ctrl #(.WIDTH(64)) u_dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(st64), .i_op_sub(sub64), .i_a(a64), .i_b(b64),
    .o_busy(busy64), .o_done(done64), .o_result(res64), .o_flags(fl64)
  );

  // Reference: {N,Z,C,V, result} from plain wide arithmetic and sign rules.
  function automatic logic [67:0] ref_op(input int w, input logic sub,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [65:0] mask, am, bm, full;
    logic [63:0] res;
    logic        n, z, c, v, sa, sb;
    mask = (66'd1 << w) - 66'd1;
    am   = {2'b00, a} & mask;
    bm   = {2'b00, b} & mask;
    full = sub ? (am + ((~bm) & mask) + 66'd1) : (am + bm);
    c    = full[w];
    res  = full[63:0] & mask[63:0];
    n    = res[w-1];
    z    = (res == 64'd0);
    sa   = am[w-1];
    sb   = bm[w-1];
    v    = sub ? ((sa != sb) && (n != sa)) : ((sa == sb) && (n != sa));
    return {n, z, c, v, res};
  endfunction

  // Issues one operation and follows it to done; lat counts falling edges after the
  // accepting edge (-1 if done never came).
  task automatic do_op(input bit wide, input logic sub, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res, output logic [3:0] fl,
                       output int lat, output int busy_cnt);
    logic d, bz;
    @(negedge clk);
    if (wide) begin st64 = 1'b1; sub64 = sub; a64 = a; b64 = b; end
    else begin st8 = 1'b1; sub8 = sub; a8 = a[7:0]; b8 = b[7:0]; end
    @(negedge clk);
    st8 = 1'b0; st64 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
    lat = -1; busy_cnt = 0; res = '0; fl = '0;
    for (int k = 1; k <= 200; k++) begin
      d  = wide ? done64 : done8;
      bz = wide ? busy64 : busy8;
      if (bz) busy_cnt++;
      if (d) begin
        lat = k;
        res = wide ? res64 : {56'd0, res8};
        fl  = wide ? fl64 : fl8;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_vec++;
    if ({busy8, done8, res8, fl8} !== 14'd0) begin
      n_err++; $display("FAIL reset8: got %h want 0", {busy8, done8, res8, fl8});
    end
    n_vec++;
    if ({busy64, done64, res64, fl64} !== 70'd0) begin
      n_err++; $display("FAIL reset64: got %h want 0", {busy64, done64, res64, fl64});
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [63:0] r; logic [3:0] f; int lat, bc;
    logic [63:0] va [4] = '{64'h7F, 64'hFF, 64'h05, 64'h00};
    logic [63:0] vb [4] = '{64'h01, 64'h01, 64'h05, 64'h01};
    logic        vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0]  er [4] = '{8'h80, 8'h00, 8'h00, 8'hFF};
    logic [3:0]  ef [4] = '{4'b1001, 4'b0110, 4'b0110, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, vs[i], va[i], vb[i], r, f, lat, bc);
      n_vec++;
      if (r[7:0] !== er[i]) begin
        n_err++; $display("FAIL directed%0d result: got %h want %h", i, r[7:0], er[i]);
      end
      n_vec++;
      if (f !== ef[i]) begin
        n_err++; $display("FAIL directed%0d flags: got %b want %b", i, f, ef[i]);
      end
      n_vec++;
      if (lat !== 9) begin
        n_err++; $display("FAIL directed%0d latency: got %0d want 9", i, lat);
      end
      n_vec++;
      if (bc !== 8) begin
        n_err++; $display("FAIL directed%0d busy cycles: got %0d want 8", i, bc);
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] a, b, r; logic [3:0] f; logic s; int lat, bc; logic [67:0] e;
    for (int i = 0; i < 36; i++) begin
      bit wide = (i % 6 == 5);
      int w = wide ? 64 : 8;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; s = 1'($urandom);
      if (i % 7 == 3) b = a;
      if (!wide) begin a = a & 64'hFF; b = b & 64'hFF; end
      e = ref_op(w, s, a, b);
      do_op(wide, s, a, b, r, f, lat, bc);
      n_vec++;
      if ({f, r} !== e) begin
        n_err++;
        $display("FAIL random%0d w%0d sub%0b a=%h b=%h: got %b/%h want %b/%h", i, w, s, a, b,
                 f, r, e[67:64], e[63:0]);
      end
      n_vec++;
      if (lat !== w + 1) begin
        n_err++; $display("FAIL random%0d latency: got %0d want %0d", i, lat, w + 1);
      end
    end
  endtask

  task automatic test_ignore_start;
    int ndone = 0; logic [7:0] r = '0; logic [67:0] e;
    e = ref_op(8, 1'b0, 64'h3C, 64'h5A);
    @(negedge clk);
    st8 = 1'b1; sub8 = 1'b0; a8 = 8'h3C; b8 = 8'h5A;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done8) begin ndone++; r = res8; end
      st8 = (k == 3 || k == 5);
      sub8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    end
    st8 = 1'b0;
    n_vec++;
    if (ndone !== 1) begin
      n_err++; $display("FAIL ignore_start done count: got %0d want 1", ndone);
    end
    n_vec++;
    if (r !== e[7:0]) begin
      n_err++; $display("FAIL ignore_start result: got %h want %h", r, e[7:0]);
    end
  endtask

  task automatic test_back_to_back;
    int d1 = -1, d2 = -1; logic [7:0] r1 = '0, r2 = '0; logic b10 = 1'b0;
    logic [67:0] e1, e2;
    e1 = ref_op(8, 1'b0, 64'hA5, 64'h33);
    e2 = ref_op(8, 1'b1, 64'h10, 64'h20);
    @(negedge clk);
    st8 = 1'b1; sub8 = 1'b0; a8 = 8'hA5; b8 = 8'h33;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done8 && d1 < 0) begin d1 = k; r1 = res8; end
      else if (done8 && d2 < 0) begin d2 = k; r2 = res8; end
      if (k == 10) b10 = busy8;
      if (k == 9) begin sub8 = 1'b1; a8 = 8'h10; b8 = 8'h20; end
      if (k == 10) st8 = 1'b0;
    end
    n_vec++;
    if (d1 !== 9 || d2 !== 18) begin
      n_err++; $display("FAIL back_to_back done cycles: got %0d,%0d want 9,18", d1, d2);
    end
    n_vec++;
    if (b10 !== 1'b1) begin
      n_err++; $display("FAIL back_to_back no idle gap: busy got %b want 1", b10);
    end
    n_vec++;
    if ({r1, r2} !== {e1[7:0], e2[7:0]}) begin
      n_err++;
      $display("FAIL back_to_back results: got %h,%h want %h,%h", r1, r2, e1[7:0], e2[7:0]);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [63:0] r; logic [3:0] f; int lat, bc;
    @(negedge clk);
    st8 = 1'b1; sub8 = 1'b0; a8 = 8'hF7; b8 = 8'h6E;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy8, done8, res8, fl8} !== 14'd0) begin
      n_err++; $display("FAIL reset_mid_run outputs: got %h want 0", {busy8, done8, res8, fl8});
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      n_vec++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        n_err++; $display("FAIL reset_mid_run aborted: got done=%b busy=%b want 0", done8, busy8);
      end
    end
    do_op(1'b0, 1'b0, 64'h12, 64'h34, r, f, lat, bc);
    n_vec++;
    if ({f, r[7:0]} !== {4'b0000, 8'h46}) begin
      n_err++; $display("FAIL reset_mid_run next op: got %b/%h want 0000/46", f, r[7:0]);
    end
  endtask

  task automatic test_wide64;
    logic [63:0] r; logic [3:0] f; int lat, bc;
    do_op(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'd1, r, f, lat, bc);
    n_vec++;
    if (r !== 64'h7FFF_FFFF_FFFF_FFFF) begin
      n_err++; $display("FAIL wide64 result: got %h want 7fffffffffffffff", r);
    end
    n_vec++;
    if (f !== 4'b0011) begin
      n_err++; $display("FAIL wide64 flags: got %b want 0011", f);
    end
    n_vec++;
    if (lat !== 65 || bc !== 64) begin
      n_err++; $display("FAIL wide64 timing: got lat %0d busy %0d want 65 64", lat, bc);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_wide64();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
